alu_mdu: RTL and testbench

//  Parametrised, handshaked execute unit for the lab CPU. It covers all twelve basic ALU ops with
//  a registered result. It adds iterative multiply and, optionally, divide/remainder.

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu_iter_core.sv | 116 +++++++++++
 rtl/alu_mdu.sv | 106 ++++++++++
 tb/tb_alu_mdu.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the alu_mdu execute unit.
//   op_t    - 4-bit operation code (16 ops)
//   state_t - control FSM state {IDLE, BUSY, DONE}
//   is_iter - true for ops that run on the iterative core
// Build option: ALU_MDU_DIV_EN selects whether DIVU/REMU are iterative
// (real divide) or complete as simple ops returning 0.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_SLT   = 4'd2,
    OP_SLTU  = 4'd3,
    OP_AND   = 4'd4,
    OP_OR    = 4'd5,
    OP_NOR   = 4'd6,
    OP_XOR   = 4'd7,
    OP_SLL   = 4'd8,
    OP_SRL   = 4'd9,
    OP_SRA   = 4'd10,
    OP_PASS  = 4'd11,
    OP_MUL   = 4'd12,
    OP_MULHU = 4'd13,
    OP_DIVU  = 4'd14,
    OP_REMU  = 4'd15
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_iter(op_t op);
`ifdef ALU_MDU_DIV_EN
    return (op inside {OP_MUL, OP_MULHU, OP_DIVU, OP_REMU});
`else
    return (op inside {OP_MUL, OP_MULHU});
`endif
  endfunction

endpackage

// File: rtl/alu_iter_core.sv
// alu_iter_core: one-bit-per-cycle shift-add multiplier and, when
// ALU_MDU_DIV_EN is defined, a restoring divider. Runs exactly WIDTH
// iteration cycles after start.
// Ports:
//   clk, rstn  - clock, synchronous active-low reset
//   start      - load operands (a = src0, b = src1) and op, begin iterating
//   op         - MUL / MULHU / DIVU / REMU
//   a, b       - operands
//   done       - high during the final iteration cycle
//   result     - value produced by the final iteration (valid with done)
import alu_pkg::*;

module alu_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  logic             running;
  logic [CW-1:0]    cnt;
  op_t              op_q;

  // Multiplier: upper half accumulates, lower half holds the multiplier
  // and shifts out one bit per cycle.
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH:0]     sum;

  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mcand : '0)};
    acc_nxt = {sum, acc[WIDTH-1:1]};
  end

`ifdef ALU_MDU_DIV_EN
  // Restoring divider: quo shifts dividend bits into rem; a subtraction
  // without borrow sets the quotient bit. A zero divisor never borrows,
  // which yields all-ones quotient and rem == dividend naturally.
  logic [WIDTH-1:0] dvsr, quo, quo_nxt, rem, rem_nxt;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, dvsr};
    if (!diff[WIDTH+1]) begin
      rem_nxt = diff[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt = shifted[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b0};
    end
  end
`endif

  always_comb begin
    result = acc_nxt[WIDTH-1:0];
    case (op_q)
      OP_MULHU: result = acc_nxt[2*WIDTH-1:WIDTH];
`ifdef ALU_MDU_DIV_EN
      OP_DIVU:  result = quo_nxt;
      OP_REMU:  result = rem_nxt;
`endif
      default:  result = acc_nxt[WIDTH-1:0];
    endcase
  end

  assign done = running && (cnt == CW'(WIDTH-1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      running <= 1'b0;
      cnt     <= '0;
      op_q    <= OP_MUL;
      acc     <= '0;
      mcand   <= '0;
`ifdef ALU_MDU_DIV_EN
      dvsr    <= '0;
      quo     <= '0;
      rem     <= '0;
`endif
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      op_q    <= op;
      acc     <= {{WIDTH{1'b0}}, b};
      mcand   <= a;
`ifdef ALU_MDU_DIV_EN
      dvsr    <= b;
      quo     <= a;
      rem     <= '0;
`endif
    end else if (running) begin
      acc <= acc_nxt;
`ifdef ALU_MDU_DIV_EN
      quo <= quo_nxt;
      rem <= rem_nxt;
`endif
      if (done) begin
        running <= 1'b0;
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: handshaked execute unit. Simple ALU ops (0..11) return one
// cycle after accept; MUL/MULHU (and DIVU/REMU with ALU_MDU_DIV_EN) run
// WIDTH cycles on alu_iter_core. Without ALU_MDU_DIV_EN, ops 14/15 are
// simple ops returning 0.
// Ports:
//   clk, rstn           - clock, synchronous active-low reset
//   in_valid/in_ready   - request handshake for op/src0/src1
//   op, src0, src1      - operation and operands (latched on accept)
//   out_valid/out_ready - result handshake; res held under backpressure
//   res                 - registered result
//   busy                - iterative op in progress
// Handshake: a transfer happens on a rising edge where valid & ready are
// both high. valid, once raised, stays high with stable data until that
// transfer. in_ready depends combinationally on out_ready so a consumer
// taking the result can admit the next op in the same cycle.
import alu_pkg::*;

module alu_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src0,
  input  logic [WIDTH-1:0] src1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  state_t           state, next_state;
  op_t              op_e;
  logic             accept, iter_op;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] simple_res;
  logic             core_done;
  logic [WIDTH-1:0] core_res;

  assign op_e      = op_t'(op);
  assign iter_op   = is_iter(op_e);
  assign shamt     = src1[SHW-1:0];
  assign in_ready  = rstn && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state == BUSY);

  always_comb begin
    simple_res = '0;
    case (op_e)
      OP_ADD:  simple_res = src0 + src1;
      OP_SUB:  simple_res = src0 - src1;
      OP_SLT:  simple_res[0] = ($signed(src0) < $signed(src1));
      OP_SLTU: simple_res[0] = (src0 < src1);
      OP_AND:  simple_res = src0 & src1;
      OP_OR:   simple_res = src0 | src1;
      OP_NOR:  simple_res = ~(src0 | src1);
      OP_XOR:  simple_res = src0 ^ src1;
      OP_SLL:  simple_res = src0 << shamt;
      OP_SRL:  simple_res = src0 >> shamt;
      OP_SRA:  simple_res = $signed(src0) >>> shamt;
      OP_PASS: simple_res = src1;
      default: simple_res = '0;
    endcase
  end

  alu_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rstn   (rstn),
    .start  (accept && iter_op),
    .op     (op_e),
    .a      (src0),
    .b      (src1),
    .done   (core_done),
    .result (core_res)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = iter_op ? BUSY : DONE;
      BUSY: if (core_done) next_state = DONE;
      DONE: begin
        if (accept)         next_state = iter_op ? BUSY : DONE;
        else if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      res   <= '0;
    end else begin
      state <= next_state;
      if (accept && !iter_op) res <= simple_res;
      else if (core_done)     res <= core_res;
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
module tb_alu_mdu;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rstn;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] src0, src1;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] res;
  logic         busy;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  alu_mdu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src0      (src0),
    .src1      (src1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .busy      (busy)
  );

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got %h expected none at %0t", res, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("scoreboard", res, mon_exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Raises a request at a negedge, holds it until in_ready, returns #1
  // after the accepting edge with inputs scrambled.
  task automatic send(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] e, input bit push);
    int t;
    t = 0;
    @(negedge clk);
    in_valid = 1'b1; op = o; src0 = a; src1 = b;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 for op %0d", o);
      in_valid = 1'b0;
    end else begin
      if (push) exp_q.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      op   = 4'($urandom_range(0, 15));
      src0 = $urandom;
      src1 = $urandom;
    end
  endtask

  // Counts negedges after an accept until out_valid; also counts busy cycles.
  task automatic measure(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cnt++;
      if (out_valid) break;
    end
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check(name, W'(exp_q.size()), '0);
  endtask

  // ---------------- directed vectors ----------------
  localparam int NV = 12;
  logic [3:0]   v_op [NV] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                              4'd8, 4'd9, 4'd10, 4'd11};
  logic [W-1:0] v_a  [NV] = '{32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'h8000_0000,
                              32'hF0F0_1234, 32'hF0F0_1234, 32'hF0F0_1234, 32'hF0F0_1234,
                              32'h0000_0001, 32'h8000_0000, 32'h8000_0000, 32'h0000_1234};
  logic [W-1:0] v_b  [NV] = '{32'h1, 32'h1, 32'h1, 32'h1,
                              32'h0FF0_FF00, 32'h0FF0_FF00, 32'h0FF0_FF00, 32'h0FF0_FF00,
                              32'h23, 32'h4, 32'h24, 32'hCAFE_BABE};
  logic [W-1:0] v_e  [NV] = '{32'h0, 32'hFFFF_FFFF, 32'h1, 32'h0,
                              32'h00F0_1200, 32'hFFF0_FF34, 32'h000F_00CB, 32'hFF00_ED34,
                              32'h8, 32'h0800_0000, 32'hF800_0000, 32'hCAFE_BABE};

  logic [W-1:0] b2b_a [4] = '{32'd1, 32'd2, 32'd3, 32'd4};
  logic [W-1:0] b2b_b [4] = '{32'd10, 32'd20, 32'd30, 32'd40};
  logic [W-1:0] b2b_e [4] = '{32'd11, 32'd22, 32'd33, 32'd44};

  int lat, bcnt;

  initial begin
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = 4'd0; src0 = '0; src1 = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", W'(in_ready), '0);
    check("rst_out_valid", W'(out_valid), '0);
    check("rst_busy", W'(busy), '0);
    check("rst_res", res, '0);
    rstn = 1'b1;

    // Simple op latency: result visible one cycle after accept.
    send(4'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1);
    @(negedge clk);
    check("add_latency_valid", W'(out_valid), 1);
    drain("drain_first");

    for (int i = 0; i < NV; i++) send(v_op[i], v_a[i], v_b[i], v_e[i], 1'b1);
    drain("drain_simple");

    // Multiply: latency and busy duration.
    send(4'd12, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1);
    measure(lat, bcnt);
    check("mul_latency", W'(lat), 33);
    check("mul_busy_cycles", W'(bcnt), 32);
    send(4'd13, 32'h0001_0000, 32'h0001_0000, 32'h1, 1'b1);
    send(4'd12, 32'd7, 32'd6, 32'd42, 1'b1);
    send(4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
    drain("drain_mul");

`ifdef ALU_MDU_DIV_EN
    send(4'd14, 32'd100, 32'd7, 32'd14, 1'b1);
    measure(lat, bcnt);
    check("divu_latency", W'(lat), 33);
    send(4'd15, 32'd100, 32'd7, 32'd2, 1'b1);
    send(4'd14, 32'd12345, 32'd0, 32'hFFFF_FFFF, 1'b1);
    send(4'd15, 32'd5, 32'd0, 32'd5, 1'b1);
`else
    send(4'd14, 32'd100, 32'd7, 32'd0, 1'b1);
    measure(lat, bcnt);
    check("divu_off_latency", W'(lat), 1);
    send(4'd15, 32'd5, 32'd0, 32'd0, 1'b1);
`endif
    drain("drain_div");

    // Backpressure: result held five cycles, unit not ready.
    @(posedge clk); #2;
    out_ready = 1'b0;
    send(4'd0, 32'd10, 32'd20, 32'd30, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", W'(out_valid), 1);
      check("bp_res", res, 32'd30);
      check("bp_in_ready", W'(in_ready), '0);
    end

    // Release together with new requests: one ADD retires per cycle.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      out_ready = 1'b1;
      in_valid = 1'b1; op = 4'd0; src0 = b2b_a[i]; src1 = b2b_b[i];
      exp_q.push_back(b2b_e[i]);
      @(negedge clk);
      check("b2b_out_valid", W'(out_valid), 1);
      check("b2b_in_ready", W'(in_ready), 1);
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
    drain("drain_b2b");

    // Reset in the middle of a multiply abandons it.
    send(4'd12, 32'd5, 32'd6, 32'd0, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", W'(out_valid), '0);
    check("midrst_busy", W'(busy), '0);
    check("midrst_res", res, '0);
    check("midrst_in_ready", W'(in_ready), '0);
    rstn = 1'b1;
    send(4'd0, 32'd2, 32'd3, 32'd5, 1'b1);
    @(negedge clk);
    check("post_rst_add_valid", W'(out_valid), 1);
    repeat (40) @(negedge clk);
    drain("drain_final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
